toy_bus_req_arb: RTL and testbench

//  N-way round-robin arbiter sharing one toy_bus request channel among master nodes (fetch, lsu, ...).

---
 rtl/toy_bus_arb_pkg.sv | 16 +
 rtl/toy_bus_rr_pick.sv | 27 ++
 rtl/toy_bus_req_arb.sv | 174 +++++++++++++++++
 tb/tb_toy_bus_req_arb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_arb_pkg.sv
// Shared constants for the toy_bus request arbiter: default widths, node ids,
// and the sizing rule for the per-master outstanding-request counters.
package toy_bus_arb_pkg;

    localparam int DEF_ID_W        = 4;
    localparam int DEF_SRC_ID_BASE = 0;

    localparam int NODE_FETCH = 0;
    localparam int NODE_LSU   = 1;

    // Counter must hold the full range 0..max_ost inclusive.
    function automatic int ost_cnt_w(input int max_ost);
        return $clog2(max_ost + 1);
    endfunction

endpackage

// File: rtl/toy_bus_rr_pick.sv
// Round-robin picker: first set request bit scanning from ptr upward (mod N),
// returned as a one-hot grant plus its binary index.
module toy_bus_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && req[(int'(ptr) + off) % N]) begin
                grant[(int'(ptr) + off) % N] = 1'b1;
                idx = PW'((int'(ptr) + off) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_bus_req_arb.sv
// Round-robin arbiter sharing one toy_bus request channel among N_IN masters,
// with a registered output stage, per-master outstanding caps and ack routing.
module toy_bus_req_arb
    import toy_bus_arb_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int STRB_W      = 32,
    parameter int SB_W        = 32,
    parameter int ID_W        = DEF_ID_W,
    parameter int SRC_ID_BASE = DEF_SRC_ID_BASE,
    parameter int MAX_OST     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          in_req_vld,
    output logic [N_IN-1:0]          in_req_rdy,
    input  logic [N_IN*ADDR_W-1:0]   in_req_addr,
    input  logic [N_IN*DATA_W-1:0]   in_req_data,
    input  logic [N_IN*STRB_W-1:0]   in_req_strb,
    input  logic [N_IN-1:0]          in_req_opcode,
    input  logic [N_IN*ID_W-1:0]     in_req_tgt_id,
    input  logic [N_IN*SB_W-1:0]     in_req_sideband,
    output logic [N_IN-1:0]          in_ack_vld,
    input  logic [N_IN-1:0]          in_ack_rdy,
    output logic [DATA_W-1:0]        in_ack_data,
    output logic [SB_W-1:0]          in_ack_sideband,
    output logic                     out_req_vld,
    input  logic                     out_req_rdy,
    output logic [ADDR_W-1:0]        out_req_addr,
    output logic [DATA_W-1:0]        out_req_data,
    output logic [STRB_W-1:0]        out_req_strb,
    output logic                     out_req_opcode,
    output logic [ID_W-1:0]          out_req_src_id,
    output logic [ID_W-1:0]          out_req_tgt_id,
    output logic [SB_W-1:0]          out_req_sideband,
    input  logic                     out_ack_vld,
    output logic                     out_ack_rdy,
    input  logic [DATA_W-1:0]        out_ack_data,
    input  logic [SB_W-1:0]          out_ack_sideband,
    input  logic [ID_W-1:0]          out_ack_tgt_id,
    output logic                     ack_err
);

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = ost_cnt_w(MAX_OST);

    logic [PW-1:0]     rr_ptr_reg;
    logic [CW-1:0]     ost_cnt_reg [N_IN];
    logic [N_IN-1:0]   eligible;
    logic [N_IN-1:0]   grant;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic              load;
    logic              accept;
    logic [N_IN-1:0]   ack_match;
    logic [N_IN-1:0]   ack_hs;
    logic              ack_hit;

    logic [ADDR_W-1:0] req_addr [N_IN];
    logic [DATA_W-1:0] req_data [N_IN];
    logic [STRB_W-1:0] req_strb [N_IN];
    logic [ID_W-1:0]   req_tgt  [N_IN];
    logic [SB_W-1:0]   req_sb   [N_IN];

    logic              out_req_vld_reg;
    logic [ADDR_W-1:0] out_req_addr_reg;
    logic [DATA_W-1:0] out_req_data_reg;
    logic [STRB_W-1:0] out_req_strb_reg;
    logic              out_req_opcode_reg;
    logic [ID_W-1:0]   out_req_src_id_reg;
    logic [ID_W-1:0]   out_req_tgt_id_reg;
    logic [SB_W-1:0]   out_req_sb_reg;
    logic              ack_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_master
            assign req_addr[gi] = in_req_addr[gi*ADDR_W +: ADDR_W];
            assign req_data[gi] = in_req_data[gi*DATA_W +: DATA_W];
            assign req_strb[gi] = in_req_strb[gi*STRB_W +: STRB_W];
            assign req_tgt[gi]  = in_req_tgt_id[gi*ID_W +: ID_W];
            assign req_sb[gi]   = in_req_sideband[gi*SB_W +: SB_W];

            assign eligible[gi]   = in_req_vld[gi] & (ost_cnt_reg[gi] < CW'(MAX_OST));
            assign ack_match[gi]  = (out_ack_tgt_id == ID_W'(SRC_ID_BASE + gi));
            assign in_ack_vld[gi] = out_ack_vld & ack_match[gi];
            assign ack_hs[gi]     = in_ack_vld[gi] & in_ack_rdy[gi];

            logic ost_inc;
            logic ost_dec;
            assign ost_inc = accept & grant[gi];
            // An ack arriving with nothing outstanding is dropped silently.
            assign ost_dec = ack_hs[gi] & (ost_cnt_reg[gi] != '0);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ost_cnt_reg[gi] <= '0;
                end else if (ost_inc && !ost_dec) begin
                    ost_cnt_reg[gi] <= ost_cnt_reg[gi] + 1'b1;
                end else if (ost_dec && !ost_inc) begin
                    ost_cnt_reg[gi] <= ost_cnt_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    toy_bus_rr_pick #(
        .N  (N_IN),
        .PW (PW)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign load       = ~out_req_vld_reg | out_req_rdy;
    assign accept     = rst_n & load & pick_any;
    assign in_req_rdy = (rst_n && load) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_req_vld_reg    <= 1'b0;
            out_req_addr_reg   <= '0;
            out_req_data_reg   <= '0;
            out_req_strb_reg   <= '0;
            out_req_opcode_reg <= 1'b0;
            out_req_src_id_reg <= '0;
            out_req_tgt_id_reg <= '0;
            out_req_sb_reg     <= '0;
            rr_ptr_reg         <= '0;
        end else if (accept) begin
            out_req_vld_reg    <= 1'b1;
            out_req_addr_reg   <= req_addr[pick_idx];
            out_req_data_reg   <= req_data[pick_idx];
            out_req_strb_reg   <= req_strb[pick_idx];
            out_req_opcode_reg <= in_req_opcode[pick_idx];
            out_req_src_id_reg <= ID_W'(SRC_ID_BASE) + ID_W'(pick_idx);
            out_req_tgt_id_reg <= req_tgt[pick_idx];
            out_req_sb_reg     <= req_sb[pick_idx];
            rr_ptr_reg         <= (pick_idx == PW'(N_IN - 1)) ? '0 : pick_idx + 1'b1;
        end else if (out_req_rdy) begin
            out_req_vld_reg    <= 1'b0;
        end
    end

    // Acks for unknown ids are sunk so the fabric never stalls on them.
    assign ack_hit     = |ack_match;
    assign out_ack_rdy = ack_hit ? |(ack_match & in_ack_rdy) : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_err_reg <= 1'b0;
        end else begin
            ack_err_reg <= out_ack_vld & ~ack_hit;
        end
    end

    assign in_ack_data      = out_ack_data;
    assign in_ack_sideband  = out_ack_sideband;
    assign out_req_vld      = out_req_vld_reg;
    assign out_req_addr     = out_req_addr_reg;
    assign out_req_data     = out_req_data_reg;
    assign out_req_strb     = out_req_strb_reg;
    assign out_req_opcode   = out_req_opcode_reg;
    assign out_req_src_id   = out_req_src_id_reg;
    assign out_req_tgt_id   = out_req_tgt_id_reg;
    assign out_req_sideband = out_req_sb_reg;
    assign ack_err          = ack_err_reg;

endmodule

// File: tb/tb_toy_bus_req_arb.sv
// Directed bench for toy_bus_req_arb: stimulus pushes expected requests into a
// scoreboard queue, a monitor pops and compares on every fabric handshake.
module tb_toy_bus_req_arb;

    localparam int N_IN   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int STRB_W = 32;
    localparam int SB_W   = 32;
    localparam int ID_W   = 4;

    typedef struct {
        logic [ID_W-1:0]   src;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              op;
        logic [ID_W-1:0]   tgt;
        logic [SB_W-1:0]   sb;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_IN-1:0]        in_req_vld;
    logic [N_IN-1:0]        in_req_rdy;
    logic [N_IN*ADDR_W-1:0] in_req_addr;
    logic [N_IN*DATA_W-1:0] in_req_data;
    logic [N_IN*STRB_W-1:0] in_req_strb;
    logic [N_IN-1:0]        in_req_opcode;
    logic [N_IN*ID_W-1:0]   in_req_tgt_id;
    logic [N_IN*SB_W-1:0]   in_req_sideband;
    logic [N_IN-1:0]        in_ack_vld;
    logic [N_IN-1:0]        in_ack_rdy;
    logic [DATA_W-1:0]      in_ack_data;
    logic [SB_W-1:0]        in_ack_sideband;
    logic                   out_req_vld;
    logic                   out_req_rdy;
    logic [ADDR_W-1:0]      out_req_addr;
    logic [DATA_W-1:0]      out_req_data;
    logic [STRB_W-1:0]      out_req_strb;
    logic                   out_req_opcode;
    logic [ID_W-1:0]        out_req_src_id;
    logic [ID_W-1:0]        out_req_tgt_id;
    logic [SB_W-1:0]        out_req_sideband;
    logic                   out_ack_vld;
    logic                   out_ack_rdy;
    logic [DATA_W-1:0]      out_ack_data;
    logic [SB_W-1:0]        out_ack_sideband;
    logic [ID_W-1:0]        out_ack_tgt_id;
    logic                   ack_err;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   ver[N_IN];
    int   a0;

    always #5 clk = ~clk;

    toy_bus_req_arb #(
        .N_IN(N_IN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
        .SB_W(SB_W), .ID_W(ID_W), .SRC_ID_BASE(0), .MAX_OST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data),
        .in_req_strb(in_req_strb), .in_req_opcode(in_req_opcode),
        .in_req_tgt_id(in_req_tgt_id), .in_req_sideband(in_req_sideband),
        .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy),
        .in_ack_data(in_ack_data), .in_ack_sideband(in_ack_sideband),
        .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy),
        .out_req_addr(out_req_addr), .out_req_data(out_req_data),
        .out_req_strb(out_req_strb), .out_req_opcode(out_req_opcode),
        .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id),
        .out_req_sideband(out_req_sideband),
        .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy),
        .out_ack_data(out_ack_data), .out_ack_sideband(out_ack_sideband),
        .out_ack_tgt_id(out_ack_tgt_id), .ack_err(ack_err)
    );

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int m, input int v);
        exp_t e;
        e.src  = ID_W'(m);
        e.addr = 32'hA000_0000 | (32'(m) << 16) | 32'(v);
        e.data = {8{e.addr ^ 32'h5A5A_5A5A}};
        e.strb = ~e.addr;
        e.op   = v[0];
        e.tgt  = ID_W'(m + 5);
        e.sb   = e.addr + 32'd1;
        return e;
    endfunction

    task automatic drive(input int m);
        exp_t e;
        e = mk(m, ver[m]);
        in_req_addr[m*ADDR_W +: ADDR_W]     = e.addr;
        in_req_data[m*DATA_W +: DATA_W]     = e.data;
        in_req_strb[m*STRB_W +: STRB_W]     = e.strb;
        in_req_opcode[m]                    = e.op;
        in_req_tgt_id[m*ID_W +: ID_W]       = e.tgt;
        in_req_sideband[m*SB_W +: SB_W]     = e.sb;
    endtask

    task automatic push(input int m);
        sb_q.push_back(mk(m, ver[m]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard pop per fabric handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_req_vld === 1'b1 && out_req_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("req src=%0d addr=%08h", out_req_src_id, out_req_addr);
                chk("mon_src_id", out_req_src_id, mon_e.src);
                chk("mon_addr", out_req_addr, mon_e.addr);
                chk("mon_data", out_req_data, mon_e.data);
                chk("mon_strb", out_req_strb, mon_e.strb);
                chk("mon_opcode", out_req_opcode, mon_e.op);
                chk("mon_tgt_id", out_req_tgt_id, mon_e.tgt);
                chk("mon_sideband", out_req_sideband, mon_e.sb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_req_vld = '1; in_req_addr = '0; in_req_data = '0; in_req_strb = '0;
        in_req_opcode = '0; in_req_tgt_id = '0; in_req_sideband = '0;
        in_ack_rdy = '0; out_req_rdy = 1'b1;
        out_ack_vld = 1'b0; out_ack_tgt_id = '0;
        out_ack_data = {8{32'hC0FFEE00}}; out_ack_sideband = 32'h1234;
        ver[0] = 0; ver[1] = 0;
        drive(0); drive(1);

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_req_rdy", in_req_rdy, 0);
            chk("rst_out_req_vld", out_req_vld, 0);
        end
        step();
        rst_n = 1'b1;

        // Fairness: both masters requesting alternate 0,1,0,1 at full rate.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fair_rdy", in_req_rdy, (k % 2 == 1) ? 2'b10 : 2'b01);
            push(k % 2);
            step();
            ver[k % 2]++;
            drive(k % 2);
        end
        in_req_vld = '0;
        @(negedge clk);
        chk("fair_last_vld", out_req_vld, 1);
        step();
        @(negedge clk);
        chk("idle_vld", out_req_vld, 0);
        step();

        // Backpressure: output must hold while the fabric stalls.
        out_req_rdy = 1'b0;
        in_req_vld  = 2'b01;
        @(negedge clk);
        chk("bp_first_rdy", in_req_rdy, 2'b01);
        push(0);
        step();
        a0 = ver[0];
        ver[0]++;
        drive(0);
        tmp_e = mk(0, a0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rdy", in_req_rdy, 0);
            chk("bp_vld", out_req_vld, 1);
            chk("bp_addr", out_req_addr, tmp_e.addr);
            chk("bp_data", out_req_data, tmp_e.data);
            chk("bp_src", out_req_src_id, 0);
            step();
        end
        out_req_rdy = 1'b1;
        @(negedge clk);
        chk("rel_rdy", in_req_rdy, 2'b01);
        push(0);
        step();
        ver[0]++;
        drive(0);
        in_req_vld = '0;
        @(negedge clk);
        step();

        // Return all credits; the fifth ack to master 0 hits an empty counter.
        out_ack_vld = 1'b1;
        in_ack_rdy  = 2'b11;
        out_ack_tgt_id = 4'd0;
        repeat (5) begin
            @(negedge clk);
            chk("ack0_vld", in_ack_vld, 2'b01);
            chk("ack0_rdy", out_ack_rdy, 1);
            step();
        end
        out_ack_tgt_id = 4'd1;
        repeat (2) begin
            @(negedge clk);
            chk("ack1_vld", in_ack_vld, 2'b10);
            step();
        end
        out_ack_vld = 1'b0;
        @(negedge clk);
        chk("ack_err_none", ack_err, 0);
        step();

        // Credit cap: four accepts then master 0 blocks until an ack returns.
        in_req_vld = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cap_rdy", in_req_rdy, 2'b01);
            push(0);
            step();
            ver[0]++;
            drive(0);
        end
        repeat (2) begin
            @(negedge clk);
            chk("cap_block", in_req_rdy, 0);
            step();
        end
        out_ack_vld = 1'b1;
        out_ack_tgt_id = 4'd0;
        in_ack_rdy = 2'b01;
        @(negedge clk);
        chk("cap_ack_vld", in_ack_vld, 2'b01);
        chk("cap_block_ack", in_req_rdy, 0);
        step();
        out_ack_vld = 1'b0;
        @(negedge clk);
        chk("cap_5th_rdy", in_req_rdy, 2'b01);
        push(0);
        step();
        ver[0]++;
        drive(0);
        in_req_vld = '0;

        // Ack routing: stalled master, then an id that matches nobody.
        out_ack_vld = 1'b1;
        out_ack_tgt_id = 4'd1;
        in_ack_rdy = 2'b01;
        @(negedge clk);
        chk("route_vld", in_ack_vld, 2'b10);
        chk("route_rdy", out_ack_rdy, 0);
        step();
        out_ack_tgt_id = 4'd9;
        @(negedge clk);
        chk("miss_vld", in_ack_vld, 0);
        chk("miss_rdy", out_ack_rdy, 1);
        chk("miss_err_pre", ack_err, 0);
        step();
        out_ack_vld = 1'b0;
        @(negedge clk);
        chk("miss_err", ack_err, 1);
        step();
        @(negedge clk);
        chk("miss_err_clr", ack_err, 0);
        step();

        // Simultaneous accept and ack on master 1 keeps its count at one.
        in_req_vld = 2'b10;
        @(negedge clk);
        chk("sim_pre_rdy", in_req_rdy, 2'b10);
        push(1);
        step();
        ver[1]++;
        drive(1);
        out_ack_vld = 1'b1;
        out_ack_tgt_id = 4'd1;
        in_ack_rdy = 2'b10;
        @(negedge clk);
        chk("sim_rdy", in_req_rdy, 2'b10);
        chk("sim_ack_vld", in_ack_vld, 2'b10);
        chk("sim_ack_rdy", out_ack_rdy, 1);
        push(1);
        step();
        out_ack_vld = 1'b0;
        ver[1]++;
        drive(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sim_fill_rdy", in_req_rdy, 2'b10);
            push(1);
            step();
            ver[1]++;
            drive(1);
        end
        @(negedge clk);
        chk("sim_cap", in_req_rdy, 0);
        step();
        in_req_vld = '0;

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        chk("sb_drained", sb_q.size(), 0);
        step();
        @(negedge clk);
        chk("end_vld", out_req_vld, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
